ir_loader: RTL

Instruction-register loader that sits directly upstream of the fetch stage. It owns the program counter, issues single-word read requests to instruction memory over a req/ack handshake, and drives the captured word onto the instruction-register bus consumed by fetch. Bit 0 of the issued word is the instruction-valid flag, so `o_ir` is all-zero whenever no instruction is being issued. It also supports downstream stall and redirect (jump).

---
 rtl/ir_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ir_loader.sv
// Instruction-register loader: owns the PC, fetches one word at a time over req/ack
// and presents it on o_ir for one unstalled cycle. Optional timeout: IR_LOADER_TIMEOUT_EN.
module ir_loader #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int RESET_PC       = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_stall,
    input  logic                  i_jump,
    input  logic [ADDR_WIDTH-1:0] i_jump_addr,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [DATA_WIDTH-1:0] o_ir,
    output logic [ADDR_WIDTH-1:0] o_pc
`ifdef IR_LOADER_TIMEOUT_EN
    ,
    output logic                  o_timeout
`endif
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_C = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] opc_q, opc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  mem_req_s;
    logic                  timeout_hit_s;

`ifdef IR_LOADER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Expiry fires on the TIMEOUT_CYCLES-th consecutive REQ cycle without ack; ack wins.
    assign timeout_hit_s = (state_q == REQ) && !i_mem_ack &&
                           (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter next-state
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (i_jump) begin
            cnt_d = {CNT_W{1'b0}};
        end else if ((state_q == REQ) && !i_mem_ack) begin
            if (timeout_hit_s) begin
                cnt_d     = {CNT_W{1'b0}};
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Wait counter and timeout pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a jump overrides everything
    always_comb begin
        state_d = state_q;
        if (i_jump) begin
            state_d = REQ;
        end else begin
            case (state_q)
                IDLE:    state_d = REQ;
                REQ: begin
                    if (i_mem_ack) begin
                        state_d = ISSUE;
                    end else if (timeout_hit_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = REQ;
                    end
                end
                ISSUE: begin
                    if (i_stall) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        mem_req_s = 1'b0;
        case (state_q)
            REQ:     mem_req_s = 1'b1;
            IDLE:    mem_req_s = 1'b0;
            ISSUE:   mem_req_s = 1'b0;
            default: mem_req_s = 1'b0;
        endcase
    end

    // Datapath next-state: PC, issued word and its address
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        opc_d = opc_q;
        if (i_jump) begin
            pc_d = i_jump_addr;
            ir_d = {DATA_WIDTH{1'b0}};
        end else begin
            case (state_q)
                REQ: begin
                    if (i_mem_ack) begin
                        ir_d  = i_mem_data;
                        opc_d = pc_q;
                        pc_d  = pc_q + ADDR_WIDTH'(1);
                    end else begin
                        ir_d = ir_q;
                    end
                end
                ISSUE: begin
                    if (i_stall) begin
                        ir_d = ir_q;
                    end else begin
                        ir_d = {DATA_WIDTH{1'b0}};
                    end
                end
                default: ir_d = ir_q;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC_C;
            opc_q <= RESET_PC_C;
            ir_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            pc_q  <= pc_d;
            opc_q <= opc_d;
            ir_q  <= ir_d;
        end
    end

    assign o_mem_req  = mem_req_s;
    assign o_mem_addr = pc_q;
    assign o_ir       = ir_q;
    assign o_pc       = opc_q;

endmodule
